// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA scan counters, sync generation and pixel output stage
//
// Divides clk down to a pixel enable, scans x/y over the full line/frame totals,
// samples the encoder's px_data once per pixel and drives registered colour and
// syncs one pixel behind the counters so that all VGA outputs stay aligned.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   px_data      in   encoder pixel bit for the current x/y
//   x, y         out  11-bit scan coordinates to the encoder
//   active       out  combinational visible-area flag for the current x/y
//   hsync, vsync out  registered syncs, asserted level SYNC_POL
//   vga_r/g/b    out  registered 4-bit colour, all ones when lit
//   frame_start  out  one-clk pulse when the counters wrap to (0,0)

module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        px_data,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0]   HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]   H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0]   V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0]   VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0]   V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic          POL      = 1'(SYNC_POL);

    logic [DW-1:0] div_q, div_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic          lit_q, lit_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          fs_q, fs_d;

    logic px_en;
    logic hs_window;
    logic vs_window;

    assign px_en     = (div_q == DIV_MAX);
    assign active    = (x_q < H_ACT) && (y_q < V_ACT);
    assign hs_window = (x_q >= HS_START) && (x_q < HS_END);
    assign vs_window = (y_q >= VS_START) && (y_q < VS_END);

    always_comb begin
        div_d   = px_en ? '0 : div_q + 1'b1;
        x_d     = x_q;
        y_d     = y_q;
        lit_d   = lit_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        fs_d    = 1'b0;
        if (px_en) begin
            // Output stage samples the pixel the counters currently hold, so
            // colour and syncs trail x/y by exactly one pixel.
            lit_d   = active && px_data;
            hsync_d = hs_window ? POL : ~POL;
            vsync_d = vs_window ? POL : ~POL;
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 11'd1;
                end
            end else begin
                x_d = x_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            lit_q   <= 1'b0;
            hsync_q <= ~POL;
            vsync_q <= ~POL;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lit_q   <= lit_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = {4{lit_q}};
    assign vga_g       = {4{lit_q}};
    assign vga_b       = {4{lit_q}};
    assign frame_start = fs_q;

endmodule
